// File: rtl/rr_arb_mux.sv
// rr_arb_mux: funnels N_CH valid/ready producers into one registered output stream; round-robin
// arbitration by default, fixed lowest-index priority when RR_ARB_MUX_FIXED_PRIO_EN is defined.
// Latency: one cycle from input handshake to out_valid; one word per cycle with out_ready held high.
// Backpressure: while a word is held (out_valid && !out_ready) every in_ready is low.
module rr_arb_mux #(
    parameter int N_CH = 8,
    parameter int DW   = 8,
    localparam int SELW = $clog2(N_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CH-1:0]      in_valid,
    input  logic [N_CH*DW-1:0]   in_data,
    output logic [N_CH-1:0]      in_ready,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    output logic [SELW-1:0]      out_ch,
    input  logic                 out_ready
);

    logic            load;
    logic            gnt_vld;
    logic [SELW-1:0] gnt_idx;
    logic [DW-1:0]   gnt_dat;
    logic            out_vld_q, out_vld_d;
    logic [DW-1:0]   out_dat_q, out_dat_d;
    logic [SELW-1:0] out_ch_q, out_ch_d;

    // Consuming the held word frees the register for a refill on the same edge.
    assign load = !out_vld_q || out_ready;

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                gnt_vld = 1'b1;
                gnt_idx = SELW'(i);
            end
        end
    end
`else
    logic [SELW-1:0] ptr_q, ptr_d;

    always_comb begin
        int idx;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < N_CH; k++) begin
            // ptr_q < N_CH, so a single subtraction keeps the scan index in range.
            idx = int'(ptr_q) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!gnt_vld && in_valid[SELW'(idx)]) begin
                gnt_vld = 1'b1;
                gnt_idx = SELW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (load && gnt_vld) begin
            ptr_d = (gnt_idx == SELW'(N_CH - 1)) ? '0 : gnt_idx + SELW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_comb begin
        gnt_dat  = '0;
        in_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt_vld && (gnt_idx == SELW'(i))) begin
                gnt_dat     = in_data[i*DW +: DW];
                in_ready[i] = load;
            end
        end
    end

    always_comb begin
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        out_ch_d  = out_ch_q;
        if (load) begin
            out_vld_d = gnt_vld;
            if (gnt_vld) begin
                out_dat_d = gnt_dat;
                out_ch_d  = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            out_ch_q  <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
            out_ch_q  <= out_ch_d;
        end
    end

    assign out_valid = out_vld_q;
    assign out_data  = out_dat_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: 8x8 instance with table vectors plus scoreboard monitor, 5x12 instance for
// the non-power-of-two wrap. Expected grants follow fixed priority when RR_ARB_MUX_FIXED_PRIO_EN is set.
module tb_rr_arb_mux;

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [7:0]  a_vld = '0;
    logic [63:0] a_dat;
    logic [7:0]  a_rdy;
    logic        a_ov;
    logic [7:0]  a_od;
    logic [2:0]  a_oc;
    logic        a_ordy = 1'b0;
    logic [7:0]  chan_dat [8];

    logic [4:0]  b_vld = '0;
    logic [59:0] b_dat;
    logic [4:0]  b_rdy;
    logic        b_ov;
    logic [11:0] b_od;
    logic [2:0]  b_oc;
    logic        b_ordy = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 8; g++) begin : g_adat
        assign a_dat[g*8 +: 8] = chan_dat[g];
    end
    for (genvar g = 0; g < 5; g++) begin : g_bdat
        assign b_dat[g*12 +: 12] = 12'(12'hA00 + g);
    end

    rr_arb_mux #(.N_CH(8), .DW(8)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_vld), .in_data(a_dat), .in_ready(a_rdy),
        .out_valid(a_ov), .out_data(a_od), .out_ch(a_oc), .out_ready(a_ordy)
    );

    rr_arb_mux #(.N_CH(5), .DW(12)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_vld), .in_data(b_dat), .in_ready(b_rdy),
        .out_valid(b_ov), .out_data(b_od), .out_ch(b_oc), .out_ready(b_ordy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: the reference model pushes the expected word at the accept cycle,
    // the entry is compared while the DUT presents it and popped when consumed.
    typedef struct packed {
        logic [2:0] ch;
        logic [7:0] dat;
    } exp_t;

    exp_t sb_q[$];
    logic m_vld = 1'b0;
    int   m_ptr = 0;

    always @(negedge clk) begin
        logic       m_load;
        int         m_gnt;
        logic [7:0] m_exp_rdy;
        exp_t       e;
        if (!rst_n) begin
            m_vld = 1'b0;
            m_ptr = 0;
            sb_q.delete();
        end else begin
            chk("mon out_valid", 32'(a_ov), 32'(m_vld));
            if (m_vld) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon scoreboard: out_valid with no expected word queued");
                end else begin
                    chk("mon out_ch", 32'(a_oc), 32'(sb_q[0].ch));
                    chk("mon out_data", 32'(a_od), 32'(sb_q[0].dat));
                    if (a_ordy) void'(sb_q.pop_front());
                end
            end
            m_load = !m_vld || a_ordy;
            m_gnt  = -1;
            for (int k = 0; k < 8; k++) begin
                int c;
                c = ((FIXED ? 0 : m_ptr) + k) % 8;
                if (m_gnt < 0 && a_vld[c]) m_gnt = c;
            end
            m_exp_rdy = (m_load && m_gnt >= 0) ? (8'd1 << m_gnt) : 8'd0;
            chk("mon in_ready", 32'(a_rdy), 32'(m_exp_rdy));
            if (m_load) begin
                m_vld = (m_gnt >= 0);
                if (m_gnt >= 0) begin
                    e.ch  = 3'(m_gnt);
                    e.dat = chan_dat[m_gnt];
                    sb_q.push_back(e);
                    m_ptr = (m_gnt + 1) % 8;
                end
            end
        end
    end

    typedef struct {
        logic [7:0] vld;
        logic       rdy;
        logic [7:0] exp_rdy;
        logic       exp_ov;
        logic [2:0] exp_ch;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int held;
        int nxt;
        int bseq[3];

        for (int i = 0; i < 8; i++) chan_dat[i] = 8'(8'h30 + i);
        chan_dat[2] = 8'hA5;

        // Expected values start from reset: ptr=0, output empty.
        tbl[0]  = '{8'b0000_0100, 1'b1, 8'h04, 1'b1, 3'd2};
        tbl[1]  = '{8'b0000_0000, 1'b1, 8'h00, 1'b0, 3'd2};
        tbl[2]  = '{8'b0000_1001, 1'b1, FIXED ? 8'h01 : 8'h08, 1'b1, FIXED ? 3'd0 : 3'd3};
        tbl[3]  = '{8'b0000_1001, 1'b1, 8'h01, 1'b1, 3'd0};
        tbl[4]  = '{8'b0000_1001, 1'b1, FIXED ? 8'h01 : 8'h08, 1'b1, FIXED ? 3'd0 : 3'd3};
        tbl[5]  = '{8'b1100_0000, 1'b0, 8'h00, 1'b1, FIXED ? 3'd0 : 3'd3};
        tbl[6]  = '{8'b1100_0000, 1'b1, 8'h40, 1'b1, 3'd6};
        tbl[7]  = '{8'b1100_0001, 1'b1, FIXED ? 8'h01 : 8'h80, 1'b1, FIXED ? 3'd0 : 3'd7};
        tbl[8]  = '{8'b1100_0001, 1'b1, 8'h01, 1'b1, 3'd0};
        tbl[9]  = '{8'b1100_0001, 1'b1, FIXED ? 8'h01 : 8'h40, 1'b1, FIXED ? 3'd0 : 3'd6};
        tbl[10] = '{8'b0010_0000, 1'b1, 8'h20, 1'b1, 3'd5};
        tbl[11] = '{8'b0000_1001, 1'b1, 8'h01, 1'b1, 3'd0};
        tbl[12] = '{8'b0000_1001, 1'b1, FIXED ? 8'h01 : 8'h08, 1'b1, FIXED ? 3'd0 : 3'd3};
        tbl[13] = '{8'b0000_0000, 1'b0, 8'h00, 1'b1, FIXED ? 3'd0 : 3'd3};
        tbl[14] = '{8'b0000_0000, 1'b1, 8'h00, 1'b0, FIXED ? 3'd0 : 3'd3};

        #1;
        chk("reset out_valid", 32'(a_ov), 32'd0);
        chk("reset out_data", 32'(a_od), 32'd0);
        chk("reset out_ch", 32'(a_oc), 32'd0);
        chk("reset b out_valid", 32'(b_ov), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            a_vld  = tbl[i].vld;
            a_ordy = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d in_ready", i), 32'(a_rdy), 32'(tbl[i].exp_rdy));
            step();
            chk($sformatf("vec%0d out_valid", i), 32'(a_ov), 32'(tbl[i].exp_ov));
            chk($sformatf("vec%0d out_ch", i), 32'(a_oc), 32'(tbl[i].exp_ch));
        end

        // Full contention from ptr=4: back-to-back words, no gaps.
        a_vld  = 8'hFF;
        a_ordy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("contend%0d out_valid", k), 32'(a_ov), 32'd1);
            chk($sformatf("contend%0d out_ch", k), 32'(a_oc), FIXED ? 32'd0 : 32'((4 + k) % 8));
        end

        held = FIXED ? 0 : 5;
        nxt  = FIXED ? 0 : 6;
        a_ordy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d in_ready", k), 32'(a_rdy), 32'd0);
            step();
            chk($sformatf("stall%0d out_valid", k), 32'(a_ov), 32'd1);
            chk($sformatf("stall%0d out_ch", k), 32'(a_oc), 32'(held));
            chk($sformatf("stall%0d out_data", k), 32'(a_od), 32'(chan_dat[held]));
        end
        a_ordy = 1'b1;
        @(negedge clk);
        chk("release in_ready", 32'(a_rdy), 32'(8'd1 << nxt));
        step();
        chk("release out_ch", 32'(a_oc), 32'(nxt));

        // Asynchronous reset with a word held in the output register.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", 32'(a_ov), 32'd0);
        chk("async reset out_data", 32'(a_od), 32'd0);
        chk("async reset out_ch", 32'(a_oc), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_vld = 8'h18;
        step();
        chk("post reset out_valid", 32'(a_ov), 32'd1);
        chk("post reset out_ch", 32'(a_oc), 32'd3);
        chk("post reset out_data", 32'(a_od), 32'h33);
        a_vld = 8'h00;
        step();
        chk("drain out_valid", 32'(a_ov), 32'd0);

        // Five channels: indices stay 0..4 and wrap 4 -> 0.
        b_vld  = 5'h1F;
        b_ordy = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            nxt = FIXED ? 0 : k % 5;
            chk($sformatf("n5 %0d out_valid", k), 32'(b_ov), 32'd1);
            chk($sformatf("n5 %0d out_ch", k), 32'(b_oc), 32'(nxt));
            chk($sformatf("n5 %0d out_data", k), 32'(b_od), 32'(12'hA00 + nxt));
        end
        // ptr now 2: skip sequence 3, 0, 3.
        bseq   = FIXED ? '{0, 0, 0} : '{3, 0, 3};
        b_vld  = 5'b01001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("n5 skip%0d in_ready", k), 32'(b_rdy), 32'(5'd1 << bseq[k]));
            step();
            chk($sformatf("n5 skip%0d out_ch", k), 32'(b_oc), 32'(bseq[k]));
        end
        b_vld = '0;
        step();
        chk("n5 drain out_valid", 32'(b_ov), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
